// File: rtl/arf156b040e2r2w0cbbehbaa4acw_gclk_pkg.sv
// Shared types and constants for the multi-channel regional clock buffer.
//   rcb_state_t : per-channel gating FSM encoding
//   DEF_HYST_W  : default width of the hysteresis count
package arf156b040e2r2w0cbbehbaa4acw_gclk_pkg;

   typedef enum logic [1:0] {
      GATED = 2'b00,
      ON    = 2'b01,
      DRAIN = 2'b10
   } rcb_state_t;

   localparam int unsigned DEF_HYST_W = 6;

endpackage

// File: rtl/arf156b040e2r2w0cbbehbaa4acw_rcb_and.sv
// Regional clock AND cell: glitch-free gated clock with LCP qualifiers.
//   ck     : grid clock
//   en     : channel enable (sampled while ck is low)
//   fd, rd : LCP bits, qualify the enable alongside en
//   ckOut  : gated regional clock, low when gated
module arf156b040e2r2w0cbbehbaa4acw_rcb_and (
   input  logic ck,
   input  logic en,
   input  logic fd,
   input  logic rd,
   output logic ckOut
);

   logic enLat;

   // Transparent while the clock is low so the enable cannot change mid-pulse.
   always_latch begin
      if (!ck) enLat <= en & fd & rd;
   end

   assign ckOut = ck & enLat;

endmodule

// File: rtl/arf156b040e2r2w0cbbehbaa4acw_rcb_chan_ctl.sv
// Per-channel gating FSM with idle hysteresis counter.
//   clk          : grid clock
//   rst          : synchronous active-high reset
//   req          : channel request (power enable or override)
//   hystCnt      : hold-off cycles, sampled only on ON -> DRAIN
//   state        : registered FSM state
//   idle         : registered, 1 while the FSM is GATED
//   activeNext_c : combinational, 1 when the next state is not GATED
module arf156b040e2r2w0cbbehbaa4acw_rcb_chan_ctl
   import arf156b040e2r2w0cbbehbaa4acw_gclk_pkg::*;
#(
   parameter int unsigned HYST_W = DEF_HYST_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [HYST_W-1:0] hystCnt,
   output rcb_state_t        state,
   output logic              idle,
   output logic              activeNext_c
);

   logic [HYST_W-1:0] cnt;

   // Look-ahead of the next state for the shared popcount.
   always_comb begin
      activeNext_c = 1'b0;
      if (!rst) begin
         case (state)
            GATED:   activeNext_c = req;
            ON:      activeNext_c = req | (hystCnt != '0);
            DRAIN:   activeNext_c = req | (cnt != HYST_W'(1));
            default: activeNext_c = 1'b0;
         endcase
      end
   end

   // State, drain counter and idle flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= GATED;
         cnt   <= '0;
         idle  <= 1'b1;
      end else begin
         case (state)
            GATED: begin
               if (req) begin
                  state <= ON;
                  idle  <= 1'b0;
               end
            end
            ON: begin
               if (!req) begin
                  if (hystCnt == '0) begin
                     state <= GATED;
                     idle  <= 1'b1;
                  end else begin
                     state <= DRAIN;
                     cnt   <= hystCnt;
                  end
               end
            end
            DRAIN: begin
               // Request wins over expiry so the clock stays continuous.
               if (req) begin
                  state <= ON;
                  cnt   <= '0;
               end else if (cnt == HYST_W'(1)) begin
                  state <= GATED;
                  cnt   <= '0;
                  idle  <= 1'b1;
               end else begin
                  cnt <= cnt - HYST_W'(1);
               end
            end
            default: begin
               state <= GATED;
               cnt   <= '0;
               idle  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/multi.sv
// Multi-channel regional clock buffer with per-channel idle hysteresis.
//   CkGridX1N      : grid clock, clocks all state
//   Rst            : synchronous active-high reset
//   RPEn, RPOvrd   : per-channel power enable / force-on override
//   FscanClkUngate : scan ungate, forces every channel clock on
//   HystCnt        : hold-off cycles after a request drops (0 = immediate)
//   Fd, Rd         : per-channel LCP bits forwarded to the AND cell
//   CkRcbX1N       : gated regional clocks
//   RcbIdle        : registered, 1 per channel while GATED
//   ActiveCnt      : registered count of channels not GATED
module multi
   import arf156b040e2r2w0cbbehbaa4acw_gclk_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned HYST_W = DEF_HYST_W,
   parameter int unsigned CNT_W  = $clog2(NUM_CH + 1)
) (
   input  logic              CkGridX1N,
   input  logic              Rst,
   input  logic [NUM_CH-1:0] RPEn,
   input  logic [NUM_CH-1:0] RPOvrd,
   input  logic              FscanClkUngate,
   input  logic [HYST_W-1:0] HystCnt,
   input  logic [NUM_CH-1:0] Fd,
   input  logic [NUM_CH-1:0] Rd,
   output logic [NUM_CH-1:0] CkRcbX1N,
   output logic [NUM_CH-1:0] RcbIdle,
   output logic [CNT_W-1:0]  ActiveCnt
);

   logic [NUM_CH-1:0] activeNext;
   logic [NUM_CH-1:0] chanEn;
   logic [CNT_W-1:0]  activeSum;

   for (genvar g = 0; g < NUM_CH; g++) begin : gChan
      rcb_state_t chState;

      arf156b040e2r2w0cbbehbaa4acw_rcb_chan_ctl #(
         .HYST_W (HYST_W)
      ) uCtl (
         .clk          (CkGridX1N),
         .rst          (Rst),
         .req          (RPEn[g] | RPOvrd[g]),
         .hystCnt      (HystCnt),
         .state        (chState),
         .idle         (RcbIdle[g]),
         .activeNext_c (activeNext[g])
      );

      // Scan bypasses the FSM without disturbing its state.
      assign chanEn[g] = (chState != GATED) | FscanClkUngate;

      arf156b040e2r2w0cbbehbaa4acw_rcb_and uAnd (
         .ck    (CkGridX1N),
         .en    (chanEn[g]),
         .fd    (Fd[g]),
         .rd    (Rd[g]),
         .ckOut (CkRcbX1N[g])
      );
   end

   // Popcount of channels that will be non-GATED after this edge.
   always_comb begin
      activeSum = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         activeSum = activeSum + CNT_W'(activeNext[i]);
      end
   end

   always_ff @(posedge CkGridX1N) begin
      if (Rst) ActiveCnt <= '0;
      else     ActiveCnt <= activeSum;
   end

endmodule

// File: tb/tb_multi.sv
// Scoreboard bench for the multi-channel regional clock buffer.
module tb_multi;

   logic       CkGridX1N = 1'b0;
   logic       Rst = 1'b1;
   logic [3:0] RPEn = '0, RPOvrd = '0, Fd = '1, Rd = '1;
   logic       FscanClkUngate = 1'b0;
   logic [5:0] HystCnt = '0;
   logic [3:0] CkRcbX1N, RcbIdle;
   logic [2:0] ActiveCnt;

   multi dut (
      .CkGridX1N      (CkGridX1N),
      .Rst            (Rst),
      .RPEn           (RPEn),
      .RPOvrd         (RPOvrd),
      .FscanClkUngate (FscanClkUngate),
      .HystCnt        (HystCnt),
      .Fd             (Fd),
      .Rd             (Rd),
      .CkRcbX1N       (CkRcbX1N),
      .RcbIdle        (RcbIdle),
      .ActiveCnt      (ActiveCnt)
   );

   always #5 CkGridX1N = ~CkGridX1N;

   typedef struct {
      string      name;
      logic [3:0] idle;
      logic [2:0] act;
      logic [3:0] ck;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;
   bit   driverDone = 1'b0;

   // Values applied at the next falling edge.
   logic       nRst = 1'b1, nScan = 1'b0;
   logic [3:0] nEn = '0, nOv = '0, nFd = '1, nRd = '1;
   logic [5:0] nHyst = '0;

   // One cycle: apply inputs while the clock is low, queue what the next edge must show.
   // ck is the set of channels expected to pulse on that edge.
   task automatic cyc(input string name, input logic [3:0] eIdle,
                      input logic [2:0] eAct, input logic [3:0] eCk);
      exp_t e;
      @(negedge CkGridX1N);
      Rst = nRst; RPEn = nEn; RPOvrd = nOv; FscanClkUngate = nScan;
      HystCnt = nHyst; Fd = nFd; Rd = nRd;
      e.name = name; e.idle = eIdle; e.act = eAct; e.ck = eCk;
      expQ.push_back(e);
   endtask

   // Monitor: sample just after each edge while the grid clock is high.
   initial begin
      exp_t e;
      forever begin
         @(posedge CkGridX1N);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checks++;
            if (RcbIdle !== e.idle) begin
               errors++;
               $display("FAIL %s RcbIdle got %h expected %h @%0t", e.name, RcbIdle, e.idle, $time);
            end
            checks++;
            if (ActiveCnt !== e.act) begin
               errors++;
               $display("FAIL %s ActiveCnt got %0d expected %0d @%0t", e.name, ActiveCnt, e.act, $time);
            end
            checks++;
            if (CkRcbX1N !== e.ck) begin
               errors++;
               $display("FAIL %s CkRcbX1N got %b expected %b @%0t", e.name, CkRcbX1N, e.ck, $time);
            end
         end
      end
   end

   initial begin
      // Reset then idle
      nRst = 1'b1;
      repeat (2) cyc("reset", 4'hF, 3'd0, 4'h0);
      nRst = 1'b0;
      repeat (3) cyc("idle", 4'hF, 3'd0, 4'h0);

      // Hysteresis of 5 on channel 0; HystCnt change mid-drain is ignored
      nHyst = 6'd5; nEn = 4'h1;
      cyc("wake0", 4'hE, 3'd1, 4'h0);
      repeat (9) cyc("on0", 4'hE, 3'd1, 4'h1);
      nEn = 4'h0;
      cyc("drop0", 4'hE, 3'd1, 4'h1);
      cyc("drain0", 4'hE, 3'd1, 4'h1);
      nHyst = 6'd1;
      repeat (3) cyc("drain0", 4'hE, 3'd1, 4'h1);
      cyc("gate0", 4'hF, 3'd0, 4'h1);
      repeat (2) cyc("off0", 4'hF, 3'd0, 4'h0);

      // Zero hysteresis on channel 1
      nHyst = 6'd0; nEn = 4'h2;
      cyc("wake1", 4'hD, 3'd1, 4'h0);
      repeat (2) cyc("on1", 4'hD, 3'd1, 4'h2);
      nEn = 4'h0;
      cyc("zdrop1", 4'hF, 3'd0, 4'h2);
      cyc("zgap1", 4'hF, 3'd0, 4'h0);
      nEn = 4'h2;
      cyc("rewake1", 4'hD, 3'd1, 4'h0);
      cyc("reon1", 4'hD, 3'd1, 4'h2);

      // Reassert on the cnt==1 edge keeps the clock continuous
      nHyst = 6'd3; nEn = 4'h0;
      repeat (3) cyc("race_drain1", 4'hD, 3'd1, 4'h2);
      nEn = 4'h2;
      repeat (3) cyc("race_on1", 4'hD, 3'd1, 4'h2);
      nHyst = 6'd0; nEn = 4'h0;
      cyc("race_gate1", 4'hF, 3'd0, 4'h2);
      cyc("race_off1", 4'hF, 3'd0, 4'h0);

      // Scan ungate with no requests: clocks run, FSMs stay GATED
      nScan = 1'b1;
      repeat (3) cyc("scan_on", 4'hF, 3'd0, 4'hF);
      nScan = 1'b0;
      cyc("scan_off", 4'hF, 3'd0, 4'h0);

      // Channel 2 via override; LCP bits qualify the clock only
      nOv = 4'h4; nHyst = 6'd2;
      cyc("wake2", 4'hB, 3'd1, 4'h0);
      cyc("on2", 4'hB, 3'd1, 4'h4);
      nFd = 4'hB;
      cyc("fd_low2", 4'hB, 3'd1, 4'h0);
      nFd = 4'hF; nRd = 4'hB;
      cyc("rd_low2", 4'hB, 3'd1, 4'h0);
      nRd = 4'hF;
      cyc("lcp_on2", 4'hB, 3'd1, 4'h4);
      nOv = 4'h0;
      repeat (2) cyc("drain2", 4'hB, 3'd1, 4'h4);
      cyc("gate2", 4'hF, 3'd0, 4'h4);
      cyc("off2", 4'hF, 3'd0, 4'h0);

      // All channels on, then reset on the third drain cycle
      nEn = 4'hF; nHyst = 6'd8;
      cyc("wake_all", 4'h0, 3'd4, 4'h0);
      cyc("on_all", 4'h0, 3'd4, 4'hF);
      nEn = 4'h0;
      repeat (3) cyc("drain_all", 4'h0, 3'd4, 4'hF);
      nRst = 1'b1;
      cyc("rst_drain", 4'hF, 3'd0, 4'hF);
      nRst = 1'b0;
      repeat (2) cyc("post_rst", 4'hF, 3'd0, 4'h0);

      driverDone = 1'b1;
   end

   // Wrap-up with a bounded wait for the scoreboard to drain.
   initial begin
      int budget;
      budget = 2000;
      while (!driverDone && budget > 0) begin
         @(posedge CkGridX1N);
         budget--;
      end
      repeat (3) @(posedge CkGridX1N);
      #2;
      checks++;
      if (!driverDone || expQ.size() != 0) begin
         errors++;
         $display("FAIL drain driverDone=%0b pending=%0d expected done with 0 pending", driverDone, expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
